audio_pwm_ref_gen: RTL and testbench
====================================

AUDIO_PWM_REF_GEN -- requirements
Module: audio_pwm_ref_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of the period counter and window bounds.
REQ-002 Parameter REF_W, default 5, width of each channel's reference level.
REQ-003 Parameter N_CH, default 2, number of independent reference channels (1..8).
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 reset_central  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  run enable; low holds the counter at 0 and forces all pwm_ref to 0.
REQ-007 period  in  CNT_W  counter modulus; sampled only at wrap; 0 means 2^CNT_W.
REQ-008 cfg_valid  in  1  configuration write request.
REQ-009 cfg_ready  out  1  high when the addressed channel can accept a write.
REQ-010 cfg_ch  in  clog2(N_CH) (min 1)  target channel.
REQ-011 cfg_start, cfg_end  in  CNT_W each  inclusive active window bounds.
REQ-012 cfg_level  in  REF_W  level driven inside the window.
REQ-013 cnt  out  CNT_W  registered period counter value.
REQ-014 wrap  out  1  one-cycle pulse in the cycle cnt returns to 0.
REQ-015 pwm_ref  out  N_CH*REF_W  registered per-channel reference; channel k occupies bits [k*REF_W +: REF_W].

Function
REQ-016 While en=1, cnt SHALL increment by 1 per cycle and return to 0 after reaching period_q-1, where period_q is the latched modulus.
REQ-017 period_q SHALL load from period in the cycle cnt wraps and in every cycle en=0; a period value of 0 SHALL give modulus 2^CNT_W.
REQ-018 wrap SHALL be 1 exactly in the cycle cnt transitions to 0 while en=1.
REQ-019 For each channel, pwm_ref SHALL equal level_act when start_act <= cnt <= end_act (unsigned); otherwise it SHALL equal 0; the output lags cnt by exactly one cycle.
REQ-020 start_act > end_act SHALL produce an empty window; the channel then outputs 0 for the whole period.
REQ-021 A write is accepted when cfg_valid and cfg_ready are both 1; accepted values go to the channel's shadow registers and set the channel's pending bit.
REQ-022 cfg_ready SHALL equal NOT pending[cfg_ch]; cfg_ch >= N_CH SHALL force cfg_ready=0 and the request is ignored.
REQ-023 Per-channel state SHALL be IDLE (pending=0) or PENDING (pending=1): IDLE->PENDING on accepted write; PENDING->IDLE on commit.
REQ-024 Commit SHALL copy shadow into active (start_act, end_act, level_act) for all pending channels in the cycle cnt wraps, or in any cycle en=0.
REQ-025 A write accepted in the same cycle as a commit SHALL remain pending and commit at the next boundary; it SHALL not be lost or applied early.
REQ-026 Active values SHALL never change mid-period while en=1, so no glitch occurs within a period.
REQ-027 When en falls, cnt SHALL be 0 and pwm_ref all 0 from the next cycle; when en rises, counting SHALL restart from 0 with period_q and active values already committed.

Reset
REQ-028 On reset_central: cnt=0, wrap=0, pwm_ref=0, pending=0, period_q=0 (2^CNT_W).
REQ-029 Active and shadow values SHALL reset to start=32000, end=2^CNT_W-1, level=6 for every channel, matching the legacy fixed reference.
REQ-030 Reset asserted mid-period or with writes pending SHALL discard the pending writes; counting resumes from 0 on the first clock after release if en=1.

Structure
REQ-031 Package audio_pwm_pkg SHALL hold the reset defaults DEF_START=32000, DEF_LEVEL=6, and the per-channel state encoding.
REQ-032 Sub-module audio_ref_channel SHALL implement one channel (shadow, active, pending bit, window compare, output register); the top instantiates N_CH copies and owns the counter and the config decode.

Verification
REQ-033 Reset release, en=1, period=0, no writes -> pwm_ref channel 0 = 0 for cnt 0..31999, = 6 for cnt 32000..65535 (one-cycle lag), wrap at 65535->0.
REQ-034 period=100, ch1 write start=10 end=19 level=31 mid-period -> no change until wrap; the next period gives exactly 10 cycles of 31.
REQ-035 Second write to ch1 while pending -> cfg_ready=0, write held off; accepted on the cycle after the wrap commit.
REQ-036 Write to ch0 coincident with the wrap cycle -> commits at the following wrap, not the current one.
REQ-037 start=50 end=40 -> channel outputs 0 across the full period; cfg_ch=N_CH -> cfg_ready=0, no state change.
REQ-038 en dropped at cnt=57 with ch0 pending -> next cycle cnt=0, pwm_ref=0, pending cleared; en re-raised -> the new window is active from cnt=0.

Source files
------------

// File: rtl/audio_pwm_pkg.sv
// Shared definitions for the audio PWM reference generator.
// Holds the legacy fixed-reference defaults and the per-channel
// configuration state encoding.
package audio_pwm_pkg;

  // Legacy fixed reference: window [DEF_START, 2^CNT_W-1] at DEF_LEVEL.
  localparam int unsigned DEF_START = 32000;
  localparam int unsigned DEF_LEVEL = 6;

  // Per-channel configuration state: shadow empty or waiting for commit.
  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/audio_ref_channel.sv
// One reference channel: shadow and active window registers, the
// pending/commit state machine, the window compare and the output register.
// Ports:
//   clk, reset_central   clock, async active-high reset
//   en_i                 run enable; low forces the output to 0
//   cnt_i                current period counter value
//   commit_i             period boundary: copy shadow to active if pending
//   wr_i                 accepted configuration write for this channel
//   wr_start_i/wr_end_i  inclusive window bounds for the write
//   wr_level_i           level for the write
//   pending_o            a write is waiting for commit
//   ref_o                registered reference level (lags cnt_i by one cycle)
module audio_ref_channel
  import audio_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REF_W = 5
) (
  input  logic             clk,
  input  logic             reset_central,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             commit_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_start_i,
  input  logic [CNT_W-1:0] wr_end_i,
  input  logic [REF_W-1:0] wr_level_i,
  output logic             pending_o,
  output logic [REF_W-1:0] ref_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] sh_start_q, sh_start_d, sh_end_q, sh_end_d;
  logic [REF_W-1:0] sh_level_q, sh_level_d;
  logic [CNT_W-1:0] act_start_q, act_start_d, act_end_q, act_end_d;
  logic [REF_W-1:0] act_level_q, act_level_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic             in_win_c;

  // State and configuration registers.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      state_q     <= CH_IDLE;
      sh_start_q  <= CNT_W'(DEF_START);
      sh_end_q    <= '1;
      sh_level_q  <= REF_W'(DEF_LEVEL);
      act_start_q <= CNT_W'(DEF_START);
      act_end_q   <= '1;
      act_level_q <= REF_W'(DEF_LEVEL);
      ref_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_start_q  <= sh_start_d;
      sh_end_q    <= sh_end_d;
      sh_level_q  <= sh_level_d;
      act_start_q <= act_start_d;
      act_end_q   <= act_end_d;
      act_level_q <= act_level_d;
      ref_q       <= ref_d;
    end
  end

  // Next-state: writes only land in IDLE (the top gates wr_i with ready),
  // so a write in a commit cycle always waits for the next boundary.
  always_comb begin
    state_d     = state_q;
    sh_start_d  = sh_start_q;
    sh_end_d    = sh_end_q;
    sh_level_d  = sh_level_q;
    act_start_d = act_start_q;
    act_end_d   = act_end_q;
    act_level_d = act_level_q;
    case (state_q)
      CH_IDLE: begin
        if (wr_i) begin
          state_d    = CH_PENDING;
          sh_start_d = wr_start_i;
          sh_end_d   = wr_end_i;
          sh_level_d = wr_level_i;
        end
      end
      CH_PENDING: begin
        if (commit_i) begin
          state_d     = CH_IDLE;
          act_start_d = sh_start_q;
          act_end_d   = sh_end_q;
          act_level_d = sh_level_q;
        end
      end
    endcase
  end

  // Window compare; start > end naturally yields an empty window.
  always_comb begin
    in_win_c = (cnt_i >= act_start_q) && (cnt_i <= act_end_q);
    ref_d    = (en_i && in_win_c) ? act_level_q : '0;
  end

  assign pending_o = (state_q == CH_PENDING);
  assign ref_o     = ref_q;

endmodule

// File: rtl/audio_pwm_ref_gen.sv
// Multi-channel audio PWM reference generator. A free-running period
// counter drives N_CH channels, each outputting its level inside an
// inclusive window; new windows are double-buffered and take effect only
// at a period boundary (or while disabled).
// Ports:
//   clk, reset_central   clock, async active-high reset
//   en                   run enable
//   period               counter modulus (0 = 2^CNT_W), sampled at wrap / while disabled
//   cfg_valid/cfg_ready  configuration write handshake
//   cfg_ch               target channel
//   cfg_start/cfg_end    inclusive window bounds
//   cfg_level            level inside the window
//   cnt                  registered period counter
//   wrap                 pulse in the cycle cnt returns to 0
//   pwm_ref              per-channel references, channel k at [k*REF_W +: REF_W]
module audio_pwm_ref_gen
  import audio_pwm_pkg::*;
#(
  parameter  int unsigned CNT_W = 16,
  parameter  int unsigned REF_W = 5,
  parameter  int unsigned N_CH  = 2,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_central,
  input  logic                  en,
  input  logic [CNT_W-1:0]      period,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_start,
  input  logic [CNT_W-1:0]      cfg_end,
  input  logic [REF_W-1:0]      cfg_level,
  output logic [CNT_W-1:0]      cnt,
  output logic                  wrap,
  output logic [N_CH*REF_W-1:0] pwm_ref
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] last_c;
  logic             at_wrap_c;
  logic             commit_c;
  logic             ch_ok_c;
  logic             sel_pend_c;
  logic [N_CH-1:0]  pend_c;
  logic [N_CH-1:0]  wr_c;

  // period_q = 0 underflows to all-ones, giving a modulus of 2^CNT_W.
  assign last_c    = period_q - CNT_W'(1);
  assign at_wrap_c = en && (cnt_q == last_c);
  assign commit_c  = at_wrap_c || !en;

  // Counter, latched modulus and wrap pulse.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (!en) begin
      cnt_d    = '0;
      period_d = period;
    end else if (at_wrap_c) begin
      cnt_d    = '0;
      period_d = period;
      wrap_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Config decode: out-of-range channels are never ready and never written.
  always_comb begin
    ch_ok_c    = (32'(cfg_ch) < N_CH);
    sel_pend_c = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(cfg_ch) == k) sel_pend_c = pend_c[k];
    end
    cfg_ready = ch_ok_c && !sel_pend_c;
    wr_c      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      wr_c[k] = cfg_valid && cfg_ready && (32'(cfg_ch) == k);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    audio_ref_channel #(
      .CNT_W(CNT_W),
      .REF_W(REF_W)
    ) u_ch (
      .clk          (clk),
      .reset_central(reset_central),
      .en_i         (en),
      .cnt_i        (cnt_q),
      .commit_i     (commit_c),
      .wr_i         (wr_c[g]),
      .wr_start_i   (cfg_start),
      .wr_end_i     (cfg_end),
      .wr_level_i   (cfg_level),
      .pending_o    (pend_c[g]),
      .ref_o        (pwm_ref[g*REF_W +: REF_W])
    );
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_audio_pwm_ref_gen.sv
// Bench for audio_pwm_ref_gen with three channels (so an out-of-range
// channel index is expressible), directed steps plus a per-cycle
// scoreboard fed by a behavioural model.
module tb_audio_pwm_ref_gen;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REF_W = 5;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned CH_W  = 2;

  typedef struct packed {
    logic [CNT_W-1:0]      cnt;
    logic                  wrap;
    logic [N_CH*REF_W-1:0] pwm;
  } out_t;

  logic                  clk = 1'b0;
  logic                  reset_central;
  logic                  en;
  logic [CNT_W-1:0]      period;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_ch;
  logic [CNT_W-1:0]      cfg_start;
  logic [CNT_W-1:0]      cfg_end;
  logic [REF_W-1:0]      cfg_level;
  logic [CNT_W-1:0]      cnt;
  logic                  wrap;
  logic [N_CH*REF_W-1:0] pwm_ref;

  int   n_cmp  = 0;
  int   n_fail = 0;
  out_t sb[$];

  // Behavioural model state.
  int m_cnt, m_per;
  int m_start[N_CH], m_end[N_CH], m_lvl[N_CH];
  int s_start[N_CH], s_end[N_CH], s_lvl[N_CH];
  bit m_pend[N_CH];
  int nz[N_CH];
  int pre_cnt;
  logic rdy;

  always #5 clk = ~clk;

  audio_pwm_ref_gen #(
    .CNT_W(CNT_W),
    .REF_W(REF_W),
    .N_CH (N_CH)
  ) dut (
    .clk          (clk),
    .reset_central(reset_central),
    .en           (en),
    .period       (period),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_start    (cfg_start),
    .cfg_end      (cfg_end),
    .cfg_level    (cfg_level),
    .cnt          (cnt),
    .wrap         (wrap),
    .pwm_ref      (pwm_ref)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch_out(input int k);
    return 32'(pwm_ref[k*REF_W +: REF_W]);
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_per = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_start[k] = 32000; m_end[k] = 65535; m_lvl[k] = 6;
      s_start[k] = 32000; s_end[k] = 65535; s_lvl[k] = 6;
      m_pend[k]  = 1'b0;
    end
  endfunction

  function automatic logic model_ready();
    int unsigned ch = cfg_ch;
    if (ch >= N_CH) return 1'b0;
    return !m_pend[ch];
  endfunction

  // Expected outputs after the coming clock edge, given current inputs.
  function automatic out_t model_step();
    out_t        e;
    int unsigned ch;
    bit          acc;
    bit          commit;
    int          modv;
    e = '0;
    if (reset_central) begin
      model_reset();
      return e;
    end
    ch  = cfg_ch;
    acc = cfg_valid && model_ready();
    if (en) begin
      modv   = (m_per == 0) ? 65536 : m_per;
      commit = (m_cnt == modv - 1);
      for (int k = 0; k < N_CH; k++) begin
        if (m_cnt >= m_start[k] && m_cnt <= m_end[k])
          e.pwm[k*REF_W +: REF_W] = REF_W'(m_lvl[k]);
      end
      e.wrap = commit;
      m_cnt  = commit ? 0 : m_cnt + 1;
      if (commit) m_per = int'(period);
    end else begin
      commit = 1'b1;
      m_cnt  = 0;
      m_per  = int'(period);
    end
    e.cnt = CNT_W'(m_cnt);
    if (commit) begin
      for (int k = 0; k < N_CH; k++) begin
        if (m_pend[k]) begin
          m_start[k] = s_start[k]; m_end[k] = s_end[k]; m_lvl[k] = s_lvl[k];
          m_pend[k]  = 1'b0;
        end
      end
    end
    if (acc) begin
      s_start[ch] = int'(cfg_start);
      s_end[ch]   = int'(cfg_end);
      s_lvl[ch]   = int'(cfg_level);
      m_pend[ch]  = 1'b1;
    end
    return e;
  endfunction

  // One clock: check ready, push expectation, clock, pop and compare.
  task automatic tick();
    out_t e;
    out_t o;
    #1;
    rdy     = cfg_ready;
    pre_cnt = int'(cnt);
    chk("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
    sb.push_back(model_step());
    @(posedge clk);
    #1;
    o = {cnt, wrap, pwm_ref};
    e = sb.pop_front();
    chk("outputs", o, e);
    for (int k = 0; k < N_CH; k++) begin
      if (o.pwm[k*REF_W +: REF_W] != '0) nz[k]++;
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (int'(cnt) != target && n < budget);
    chk($sformatf("reach_cnt_%0d", target), 32'(cnt), 32'(target));
  endtask

  initial begin
    reset_central = 1'b1;
    en            = 1'b0;
    period        = '0;
    cfg_valid     = 1'b0;
    cfg_ch        = '0;
    cfg_start     = '0;
    cfg_end       = '0;
    cfg_level     = '0;
    for (int k = 0; k < N_CH; k++) nz[k] = 0;
    model_reset();
    #1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_pwm", 32'(pwm_ref), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    #1;
    reset_central = 1'b0;
    en            = 1'b1;

    // Legacy default window with modulus 2^16.
    run_until(32000, 40000);
    chk("def_pre_start", ch_out(0), 0);
    tick();
    chk("def_at_start", ch_out(0), 6);
    period = 16'd100;
    run_until(65535, 40000);
    chk("def_no_early_wrap", 32'(wrap), 0);
    tick();
    chk("def_wrap_cnt", 32'(cnt), 0);
    chk("def_wrap_pulse", 32'(wrap), 1);
    chk("def_last_level", ch_out(0), 6);

    // Mid-period write to ch1, then a second write held off until commit.
    run_until(40, 200);
    cfg_valid = 1'b1; cfg_ch = 2'd1;
    cfg_start = 16'd10; cfg_end = 16'd19; cfg_level = 5'd31;
    tick();
    chk("b_first_accept", 32'(rdy), 1);
    cfg_start = 16'd20; cfg_end = 16'd29; cfg_level = 5'd7;
    nz[1] = 0;
    begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!rdy && n < 200);
    end
    chk("b_second_accept", 32'(rdy), 1);
    chk("b_accept_after_commit", 32'(pre_cnt), 0);
    chk("b_no_change_before_wrap", 32'(nz[1]), 0);
    cfg_valid = 1'b0;
    nz[1] = 0;
    run_until(0, 200);
    chk("b_window_len", 32'(nz[1]), 10);

    // Write to ch0 in the wrap cycle; bad channel; empty window on ch2.
    run_until(99, 200);
    cfg_valid = 1'b1; cfg_ch = 2'd0;
    cfg_start = 16'd0; cfg_end = 16'd4; cfg_level = 5'd9;
    tick();
    chk("c_accept_on_wrap", 32'(rdy), 1);
    chk("c_wrap_seen", 32'(wrap), 1);
    cfg_ch = 2'd3; cfg_start = 16'd0; cfg_end = 16'd99; cfg_level = 5'd31;
    #1;
    chk("c_bad_ch_ready", 32'(cfg_ready), 0);
    tick();
    cfg_ch = 2'd2; cfg_start = 16'd50; cfg_end = 16'd40; cfg_level = 5'd15;
    tick();
    chk("c_ch2_accept", 32'(rdy), 1);
    cfg_valid = 1'b0; cfg_ch = 2'd0;
    #1;
    chk("c_ch0_pending", 32'(cfg_ready), 0);
    nz[0] = 0; nz[2] = 0;
    run_until(0, 200);
    chk("c_no_early_commit", 32'(nz[0]), 0);
    nz[0] = 0; nz[2] = 0;
    run_until(0, 200);
    chk("c_window_len", 32'(nz[0]), 5);
    chk("c_empty_window", 32'(nz[2]), 0);

    // Disable with ch0 pending: commits, clears, restarts from 0.
    cfg_valid = 1'b1; cfg_ch = 2'd0;
    cfg_start = 16'd60; cfg_end = 16'd69; cfg_level = 5'd3;
    tick();
    chk("d_accept", 32'(rdy), 1);
    cfg_valid = 1'b0;
    run_until(57, 200);
    en = 1'b0;
    tick();
    chk("d_off_cnt", 32'(cnt), 0);
    chk("d_off_pwm", 32'(pwm_ref), 0);
    chk("d_off_wrap", 32'(wrap), 0);
    #1;
    chk("d_pending_cleared", 32'(cfg_ready), 1);
    tick();
    en = 1'b1;
    run_until(60, 200);
    chk("d_before_win", ch_out(0), 0);
    tick();
    chk("d_new_win", ch_out(0), 3);

    // Reset with a pending write discards it and restarts counting.
    cfg_valid = 1'b1; cfg_ch = 2'd1;
    cfg_start = 16'd1; cfg_end = 16'd2; cfg_level = 5'd5;
    tick();
    chk("e_accept", 32'(rdy), 1);
    cfg_valid = 1'b0;
    reset_central = 1'b1;
    #1;
    chk("e_rst_cnt", 32'(cnt), 0);
    chk("e_rst_pwm", 32'(pwm_ref), 0);
    chk("e_rst_ready", 32'(cfg_ready), 1);
    model_reset();
    tick();
    reset_central = 1'b0;
    tick();
    chk("e_resume", 32'(cnt), 1);
    nz[1] = 0;
    run_until(10, 200);
    chk("e_pending_discarded", 32'(nz[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
